// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with valid/ready request bus, load alignment and MEM/WB bubble gating.
// Optional misaligned-access trap when MEM_MISALIGN_CHECK_EN is defined.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_i_commit,
  input  logic        MEM_i_write_gpr,
  input  logic        MEM_i_write_csr,
  input  logic        MEM_i_mem_to_reg,
  input  logic        MEM_i_system_halt,
  input  logic [31:0] MEM_i_pc,
  input  logic [31:0] MEM_i_inst,
  input  logic [31:0] MEM_i_ALU_ALUout,
  input  logic [31:0] MEM_i_ALU_CSR_out,
  input  logic [31:0] MEM_i_rs2_data,
  input  logic [4:0]  MEM_i_rd,
  input  logic [2:0]  MEM_i_csr_rd,
  input  logic        MEM_i_mem_ren,
  input  logic        MEM_i_mem_wen,
  input  logic [2:0]  MEM_i_funct3,
  input  logic        MEM_i_hold,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        MEM_o_commit,
  output logic        MEM_o_write_gpr,
  output logic        MEM_o_write_csr,
  output logic        MEM_o_mem_to_reg,
  output logic        MEM_o_system_halt,
  output logic [31:0] MEM_o_pc,
  output logic [31:0] MEM_o_inst,
  output logic [31:0] MEM_o_ALU_ALUout,
  output logic [31:0] MEM_o_ALU_CSR_out,
  output logic [31:0] MEM_o_rs2_data,
  output logic [4:0]  MEM_o_rd,
  output logic [2:0]  MEM_o_csr_rd,
  output logic [31:0] MEM_o_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        MEM_o_misalign,
`endif
  output logic        MEM_o_busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sh, ext;
  logic [3:0] wstrb_q, wstrb_d, strb;
  logic [2:0] f3_q, f3_d;
  logic [1:0] a_q, a_d, a;
  logic wen_q, wen_d, mis_q, mis_d, is_mem, mis, rsp_edge, mis_done;
  assign a = MEM_i_ALU_ALUout[1:0];
  assign is_mem = MEM_i_mem_ren | MEM_i_mem_wen;
  assign strb = MEM_i_funct3[1:0] == 2'b00 ? 4'b0001 << a :
                MEM_i_funct3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = (MEM_i_funct3[1:0] == 2'b01 & a[0]) | (MEM_i_funct3[1:0] == 2'b10 & a != 2'b00);
  assign MEM_o_misalign = mis_done;
`else
  assign mis = 1'b0;
`endif
  assign sh = mem_rsp_rdata >> {a_q, 3'b000};
  assign ext = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
               f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
               f3_q == 3'b100 ? {24'b0, sh[7:0]} :
               f3_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
  assign rsp_edge = mem_rsp_valid & ((state_q == REQ & mem_req_ready) | state_q == WAIT);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wen_d   = wen_q;
    f3_d    = f3_q;
    a_d     = a_q;
    mis_d   = mis_q;
    rdata_d = rsp_edge & ~wen_q ? ext : rdata_q;
    case (state_q)
      IDLE: if (is_mem & ~MEM_i_hold) begin
        state_d = mis ? DONE : REQ;
        addr_d  = {MEM_i_ALU_ALUout[31:2], 2'b00};
        wdata_d = MEM_i_rs2_data << {a, 3'b000};
        wstrb_d = strb;
        wen_d   = MEM_i_mem_wen;
        f3_d    = MEM_i_funct3;
        a_d     = a;
        mis_d   = mis;
      end
      REQ:  state_d = mem_req_ready ? (mem_rsp_valid ? DONE : WAIT) : REQ;
      WAIT: state_d = mem_rsp_valid ? DONE : WAIT;
      DONE: state_d = MEM_i_hold ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      a_q     <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wen_q   <= wen_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign MEM_o_busy = (state_q == IDLE & is_mem) | state_q == REQ | state_q == WAIT;
  // A trapped misaligned access retires as a halt with no architectural write.
  assign mis_done = state_q == DONE & mis_q;
  assign MEM_o_commit      = MEM_i_commit & ~MEM_o_busy & ~mis_done;
  assign MEM_o_write_gpr   = MEM_i_write_gpr & ~MEM_o_busy & ~mis_done;
  assign MEM_o_write_csr   = MEM_i_write_csr & ~MEM_o_busy;
  assign MEM_o_system_halt = (MEM_i_system_halt | mis_done) & ~MEM_o_busy;
  assign MEM_o_mem_to_reg  = MEM_i_mem_to_reg;
  assign MEM_o_pc          = MEM_i_pc;
  assign MEM_o_inst        = MEM_i_inst;
  assign MEM_o_ALU_ALUout  = MEM_i_ALU_ALUout;
  assign MEM_o_ALU_CSR_out = MEM_i_ALU_CSR_out;
  assign MEM_o_rs2_data    = MEM_i_rs2_data;
  assign MEM_o_rd          = MEM_i_rd;
  assign MEM_o_csr_rd      = MEM_i_csr_rd;
  assign MEM_o_rdata       = rdata_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven and directed checks for mem_stage_lsu.
module tb_mem_stage_lsu;
  logic clk = 1'b0, rst = 1'b1;
  logic commit, wgpr, wcsr, m2r, halt, ren, wen, hold, ready, rsp_valid;
  logic [31:0] pc, inst, alu, csr_out, rs2, rsp_rdata;
  logic [4:0] rd;
  logic [2:0] csr_rd, f3;
  logic valid, req_wen, o_commit, o_wgpr, o_wcsr, o_m2r, o_halt, busy;
  logic [31:0] req_addr, req_wdata, o_pc, o_inst, o_alu, o_csr, o_rs2, o_rdata;
  logic [3:0] wstrb;
  logic [4:0] o_rd;
  logic [2:0] o_csr_rd;
`ifdef MEM_MISALIGN_CHECK_EN
  logic o_mis;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .MEM_i_commit(commit), .MEM_i_write_gpr(wgpr), .MEM_i_write_csr(wcsr),
    .MEM_i_mem_to_reg(m2r), .MEM_i_system_halt(halt),
    .MEM_i_pc(pc), .MEM_i_inst(inst), .MEM_i_ALU_ALUout(alu), .MEM_i_ALU_CSR_out(csr_out),
    .MEM_i_rs2_data(rs2), .MEM_i_rd(rd), .MEM_i_csr_rd(csr_rd),
    .MEM_i_mem_ren(ren), .MEM_i_mem_wen(wen), .MEM_i_funct3(f3), .MEM_i_hold(hold),
    .mem_req_valid(valid), .mem_req_ready(ready), .mem_req_addr(req_addr),
    .mem_req_wen(req_wen), .mem_req_wdata(req_wdata), .mem_req_wstrb(wstrb),
    .mem_rsp_valid(rsp_valid), .mem_rsp_rdata(rsp_rdata),
    .MEM_o_commit(o_commit), .MEM_o_write_gpr(o_wgpr), .MEM_o_write_csr(o_wcsr),
    .MEM_o_mem_to_reg(o_m2r), .MEM_o_system_halt(o_halt),
    .MEM_o_pc(o_pc), .MEM_o_inst(o_inst), .MEM_o_ALU_ALUout(o_alu), .MEM_o_ALU_CSR_out(o_csr),
    .MEM_o_rs2_data(o_rs2), .MEM_o_rd(o_rd), .MEM_o_csr_rd(o_csr_rd), .MEM_o_rdata(o_rdata),
`ifdef MEM_MISALIGN_CHECK_EN
    .MEM_o_misalign(o_mis),
`endif
    .MEM_o_busy(busy)
  );
  typedef struct packed {
    logic ren, wen;
    logic [2:0] f3;
    logic [31:0] adr, rs2, rsp, e_addr;
    logic [3:0] e_strb;
    logic [31:0] e_wdata, e_rdata;
  } vec_t;
  vec_t v [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    v[0] = '{1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'h8000_0004, 4'hF, 32'h0, 32'hDEAD_BEEF};
    v[1] = '{1'b1, 1'b0, 3'b000, 32'h8000_0103, 32'h0, 32'h8012_3456, 32'h8000_0100, 4'h8, 32'h0, 32'hFFFF_FF80};
    v[2] = '{1'b1, 1'b0, 3'b100, 32'h8000_0103, 32'h0, 32'h8012_3456, 32'h8000_0100, 4'h8, 32'h0, 32'h0000_0080};
    v[3] = '{1'b0, 1'b1, 3'b001, 32'h8000_0202, 32'h0000_1234, 32'h0, 32'h8000_0200, 4'hC, 32'h1234_0000, 32'h0000_0080};
    v[4] = '{1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 32'h0000_0004, 4'hC, 32'h0, 32'hFFFF_8001};
    v[5] = '{1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 32'h0000_0000, 4'hC, 32'h0, 32'h0000_8001};
    v[6] = '{1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'h1234_5678, 32'h0000_0000, 4'h2, 32'h0, 32'h0000_0056};
    v[7] = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0, 32'h0000_0000, 4'h2, 32'h0000_AB00, 32'h0000_0056};
    v[8] = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_BABE, 32'h0, 32'h0000_0010, 4'hF, 32'hCAFE_BABE, 32'h0000_0056};
    {commit, wgpr, wcsr, m2r, halt, ren, wen, hold, ready, rsp_valid} = '0;
    {pc, inst, alu, csr_out, rs2, rsp_rdata} = '0;
    rd = 5'd7; csr_rd = 3'd2; f3 = 3'b010;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_wdata", req_wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_wen", req_wen, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc;
    for (int i = 0; i < 9; i++) begin
      ren = v[i].ren; wen = v[i].wen; f3 = v[i].f3; alu = v[i].adr; rs2 = v[i].rs2;
      commit = 1'b1; wgpr = v[i].ren; ready = 1'b0; rsp_valid = 1'b0;
      #1;
      chk("c0_busy", busy, 1);
      chk("c0_commit", o_commit, 0);
      cyc;
      chk("req_valid", valid, 1);
      chk("req_busy", busy, 1);
      chk("req_addr", req_addr, v[i].e_addr);
      chk("req_wstrb", wstrb, v[i].e_strb);
      chk("req_wdata", req_wdata, v[i].e_wdata);
      chk("req_wen", req_wen, v[i].wen);
      ready = 1'b1;
      cyc;
      ready = 1'b0;
      chk("wait_valid", valid, 0);
      chk("wait_busy", busy, 1);
      rsp_valid = 1'b1; rsp_rdata = v[i].rsp;
      cyc;
      rsp_valid = 1'b0;
      chk("done_busy", busy, 0);
      chk("done_commit", o_commit, 1);
      chk("done_wgpr", o_wgpr, v[i].ren);
      chk("done_rdata", o_rdata, v[i].e_rdata);
      ren = 1'b0; wen = 1'b0;
      cyc;
      chk("idle_busy", busy, 0);
    end
    // non-memory instruction passes straight through; a stray response in IDLE is ignored
    halt = 1'b1; wcsr = 1'b1; pc = 32'h1000; rsp_valid = 1'b1; rsp_rdata = 32'h9999_9999;
    #1;
    chk("nm_busy", busy, 0);
    chk("nm_commit", o_commit, 1);
    chk("nm_halt", o_halt, 1);
    chk("nm_wcsr", o_wcsr, 1);
    chk("nm_pc", o_pc, 32'h1000);
    chk("nm_rd", o_rd, 7);
    cyc;
    chk("nm_valid", valid, 0);
    chk("nm_rdata", o_rdata, 32'h0000_0056);
    rsp_valid = 1'b0; halt = 1'b0; wcsr = 1'b0;
    // slow ready with hold during REQ, response two cycles after handshake
    ren = 1'b1; wgpr = 1'b1; f3 = 3'b010; alu = 32'h40;
    cyc;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu = 32'h77 + k;
      #1;
      chk("stall_valid", valid, 1);
      chk("stall_addr", req_addr, 32'h40);
      chk("stall_busy", busy, 1);
      chk("stall_commit", o_commit, 0);
      cyc;
    end
    hold = 1'b0; alu = 32'h40; ready = 1'b1;
    #1;
    chk("hs_valid", valid, 1);
    cyc;
    ready = 1'b0;
    chk("w1_busy", busy, 1);
    chk("w1_commit", o_commit, 0);
    cyc;
    chk("w2_busy", busy, 1);
    rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_F00D;
    cyc;
    rsp_valid = 1'b0;
    chk("slow_busy", busy, 0);
    chk("slow_rdata", o_rdata, 32'h0BAD_F00D);
    // hold DONE for two cycles with a stray response present
    hold = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h1111_1111;
    for (int k = 0; k < 2; k++) begin
      cyc;
      chk("hold_busy", busy, 0);
      chk("hold_valid", valid, 0);
      chk("hold_rdata", o_rdata, 32'h0BAD_F00D);
    end
    hold = 1'b0; rsp_valid = 1'b0;
    cyc;
    // back-to-back lw whose response coincides with the handshake
    alu = 32'h44;
    #1;
    chk("b2b_c0_busy", busy, 1);
    chk("b2b_c0_valid", valid, 0);
    ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h2222_2222;
    cyc;
    chk("b2b_valid", valid, 1);
    chk("b2b_addr", req_addr, 32'h44);
    cyc;
    ready = 1'b0; rsp_valid = 1'b0;
    chk("b2b_busy", busy, 0);
    chk("b2b_rdata", o_rdata, 32'h2222_2222);
    chk("b2b_commit", o_commit, 1);
    ren = 1'b0;
    cyc;
    // asynchronous reset while waiting for a response
    ren = 1'b1; alu = 32'h80;
    cyc;
    ready = 1'b1;
    cyc;
    ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_rdata", o_rdata, 0);
    chk("arst_addr", req_addr, 0);
    chk("arst_busy", busy, 1);
    ren = 1'b0;
    #1;
    chk("arst_idle_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    cyc;
    ren = 1'b1; f3 = 3'b010; alu = 32'h0000_0001; commit = 1'b1; wgpr = 1'b1; halt = 1'b0;
    #1;
    chk("mis_c0_busy", busy, 1);
    cyc;
    chk("mis_flag", o_mis, 1);
    chk("mis_halt", o_halt, 1);
    chk("mis_commit", o_commit, 0);
    chk("mis_wgpr", o_wgpr, 0);
    chk("mis_valid", valid, 0);
    chk("mis_busy", busy, 0);
    ren = 1'b0;
    cyc;
    chk("mis_clear", o_mis, 0);
    chk("mis_no_req", valid, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage of the 5-stage core, between the EX/MEM segment register and the MEM/WB segment register. It issues one load or store per memory instruction on a valid/ready request bus, waits for the response, and aligns and sign-extends load data. It also passes the other MEM-stage fields through to the MEM/WB register, gated so that a bubble is produced while an access is outstanding. `MEM_o_busy` is raised to the hazard unit so that it can stall IF..MEM.

## Interface
- No parameters. Width is fixed at 32-bit data/address.
- `clk  in  1`  core clock.
- `rst  in  1`  asynchronous, active-high reset.
- `MEM_i_commit, MEM_i_write_gpr, MEM_i_write_csr, MEM_i_mem_to_reg, MEM_i_system_halt  in  1 each`  from EX/MEM.
- `MEM_i_pc, MEM_i_inst, MEM_i_ALU_ALUout, MEM_i_ALU_CSR_out, MEM_i_rs2_data  in  32 each`  from EX/MEM. `ALUout` is the effective address for memory ops.
- `MEM_i_rd  in  5`, `MEM_i_csr_rd  in  3`  destination indices.
- `MEM_i_mem_ren, MEM_i_mem_wen  in  1 each`  load / store. They are never both set.
- `MEM_i_funct3  in  3`  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `MEM_i_hold  in  1`  downstream stall (same signal as `FORWARD_stallWB`).
- `mem_req_valid  out  1`, `mem_req_ready  in  1`  request handshake.
- `mem_req_addr  out  32`, `mem_req_wen  out  1`, `mem_req_wdata  out  32`, `mem_req_wstrb  out  4`  request payload.
- `mem_rsp_valid  in  1`, `mem_rsp_rdata  in  32`  response. A response is always accepted.
- `MEM_o_*  out`  same names and widths as the `MEM_i_*` pass-through fields, plus `MEM_o_rdata  out  32`.
- `MEM_o_busy  out  1`  access in progress. The hazard unit stalls IF..MEM and the MEM/WB register loads the gated bubble.
- `MEM_o_misalign  out  1`  only present with the macro below.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**: if `(mem_ren|mem_wen) & ~MEM_i_hold`, go to REQ. On that edge, capture into request registers:
  - `addr = {ALUout[31:2],2'b00}`
  - `wen`
  - `wstrb`: b→`0001<<a`, h→`0011<<a`, w→`1111`, where a=`ALUout[1:0]`
  - `wdata = rs2_data << (8*a)`
  - `funct3` and `a`, held for alignment.
- **REQ**: `mem_req_valid=1`, payload stable. If `mem_req_ready`, go to WAIT. If `mem_rsp_valid` is also high in that cycle, go straight to DONE.
- **WAIT**: on `mem_rsp_valid`, go to DONE. Stores also wait for the response; their write acknowledge carries no data.
- On the response edge (loads only), `MEM_o_rdata` is registered as:
  - `rsp_rdata >> (8*a)`, truncated to the access size;
  - sign-extended for b/h, zero-extended for bu/hu.
  - Stores leave `MEM_o_rdata` unchanged.
- **DONE**: `MEM_o_busy=0`, so the result is presented to MEM/WB. Go to IDLE when `~MEM_i_hold`, otherwise stay. No new request is issued from DONE, so the same instruction is never re-issued.
- `MEM_o_busy = (IDLE & (mem_ren|mem_wen)) | REQ | WAIT`.
- Gated outputs: `MEM_o_commit`, `MEM_o_write_gpr`, `MEM_o_write_csr` and `MEM_o_system_halt` equal their inputs ANDed with `~MEM_o_busy`. All other `MEM_o_*` pass through combinationally.
- Non-memory instructions see zero added latency. The FSM stays in IDLE, `MEM_o_rdata` holds its last value and `MEM_o_busy=0`.

## Timing
- Reset (async) values:
  - state IDLE;
  - `mem_req_valid=0`; `mem_req_addr`, `mem_req_wdata` and `mem_req_wstrb` 0; `mem_req_wen=0`;
  - `MEM_o_rdata=0`, `MEM_o_misalign=0`.
  - `MEM_o_busy` follows IDLE decode of the inputs.
- Zero-wait memory takes 4 cycles in MEM:
  - c0 IDLE, busy=1;
  - c1 REQ, ready=1;
  - c2 WAIT, rsp;
  - c3 DONE, busy=0. The MEM/WB register captures at the end of c3.
- If the response coincides with the handshake (c1), the access takes 3 cycles.
- `mem_req_valid` never drops and the payload never changes before `ready`.
- A `mem_rsp_valid` seen in IDLE or DONE is ignored.
- `MEM_i_hold` during REQ or WAIT does not affect the bus transaction. It only extends DONE.
- Reset asserted mid-transaction aborts to IDLE immediately. The memory side must also be reset.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - A condition is misaligned if h has `a[0]=1`, or w has `a!=0`.
  - On a misaligned access in IDLE, no request is issued and the FSM goes to DONE on the next edge. `busy` is 1 for that one cycle.
  - In DONE, `MEM_o_misalign=1` and `MEM_o_system_halt=1`. `MEM_o_commit` and `MEM_o_write_gpr` are 0.
- Macro undefined:
  - No check is made. The misaligned low address bits are dropped and the access proceeds with the computed strobe, which is truncated at the word boundary.
  - The `MEM_o_misalign` port is absent.

## Test plan
- lw at 0x8000_0004, ready=1, rsp the next cycle with 0xDEAD_BEEF → `mem_req_addr=0x8000_0004`; `MEM_o_rdata=0xDEAD_BEEF` and `MEM_o_commit=1` in DONE; busy for exactly 3 cycles.
- lb at address 0x...03, rsp 0x80xx_xxxx → `rdata=0xFFFF_FF80`. The same case with lbu → `0x0000_0080`.
- sh at address 0x...02, rs2=0x0000_1234 → `wstrb=1100`, `wdata=0x1234_0000`, `wen=1`. `MEM_o_rdata` is unchanged.
- ready held low for 3 cycles → valid and payload stable throughout. rsp arrives 2 cycles after the handshake → DONE follows one cycle later, and no commit is seen while busy.
- hold=1 for 2 cycles in DONE → remains in DONE with rdata stable and no second `mem_req_valid`. Back to back, a second lw enters IDLE after hold drops.
- Reset asserted in WAIT → `mem_req_valid=0` and `MEM_o_rdata=0` immediately. With the macro, lw at 0x...01 → no request, and `MEM_o_misalign=1` for 1 cycle.
